// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver feeding a small byte FIFO.
// Deserialises 11-bit PS/2 frames and checks the start, stop and odd-parity bits.
// Good scan-code bytes are queued for a downstream consumer.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   clrn           synchronous reset, active-high (1 = clear)
//   ps2_clk        raw PS/2 clock pin (asynchronous)
//   ps2_data       raw PS/2 data pin (asynchronous)
//   nextdata_n     active-low pop request, one cycle low per byte
//   data           byte at the FIFO head (8'h00 while empty)
//   ready          FIFO non-empty
//   fifo_overflow  sticky: a good frame was dropped because the FIFO was full
//   frame_err      one-cycle pulse: a frame failed its start/stop/parity check
module ps2_kbd_rx #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned PTR_W       = 3,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       fifo_overflow,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYC - 1);

    // sync_q[0] = s0, sync_q[1] = s1, sync_q[2] = s2
    logic [2:0]       sync_q;
    logic [9:0]       buf_q;
    logic [3:0]       cnt_q;
    logic [TW-1:0]    tcnt_q;
    logic [PTR_W:0]   wr_q;
    logic [PTR_W:0]   rd_q;
    logic             ovf_q;
    logic             ferr_q;
    logic [7:0]       mem [FIFO_DEPTH];

    logic samp;
    logic empty;
    logic full;
    logic frame_done;
    logic frame_good;
    logic pop;
    logic push;
    logic timeout;

    always_comb begin
        samp       = sync_q[2] & ~sync_q[1];
        empty      = (wr_q == rd_q);
        full       = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                     (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
        frame_done = samp && (cnt_q == 4'd10);
        // The stop bit is taken live from the pin on the completing edge.
        frame_good = frame_done && !buf_q[0] && ps2_data && (^buf_q[9:1]);
        pop        = !nextdata_n && !empty;
        // A pop on the same edge frees a slot, so a full FIFO still accepts the byte.
        push       = frame_good && (!full || pop);
        // Idle time only accrues while ps2_clk reads high mid-frame.
        timeout    = (cnt_q != 4'd0) && !samp && sync_q[1] && (tcnt_q == TimeoutLast);
    end

    // Bit deserialiser and stall timeout.
    always_ff @(posedge clk) begin
        if (clrn) begin
            sync_q <= 3'b111;
            buf_q  <= 10'd0;
            cnt_q  <= 4'd0;
            tcnt_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], ps2_clk};
            if (samp) begin
                if (cnt_q == 4'd10) begin
                    cnt_q <= 4'd0;
                end else begin
                    buf_q <= {ps2_data, buf_q[9:1]};
                    cnt_q <= cnt_q + 4'd1;
                end
            end else if (timeout) begin
                cnt_q <= 4'd0;
            end

            if ((cnt_q == 4'd0) || samp || timeout) begin
                tcnt_q <= '0;
            end else if (sync_q[1]) begin
                tcnt_q <= tcnt_q + 1'b1;
            end
        end
    end

    // FIFO pointers and status flags.
    always_ff @(posedge clk) begin
        if (clrn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            ferr_q <= frame_done && !frame_good;
            if (frame_good && !push) begin
                ovf_q <= 1'b1;
            end else if (pop) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (push && !clrn) begin
            mem[wr_q[PTR_W-1:0]] <= buf_q[8:1];
        end
    end

    always_comb begin
        ready         = !empty;
        data          = empty ? 8'h00 : mem[rd_q[PTR_W-1:0]];
        fifo_overflow = ovf_q;
        frame_err     = ferr_q;
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed scenarios plus a randomized
// send/pop mix, all compared against a queue-based reference model.
module tb_ps2_kbd_rx;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 4096;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       fifo_overflow;
    logic       frame_err;

    int n_vec    = 0;
    int n_bad    = 0;
    int err_seen = 0;
    int err_exp  = 0;

    logic [7:0] q[$];
    bit         ovf_m = 1'b0;

    ps2_kbd_rx #(
        .FIFO_DEPTH (DEPTH),
        .PTR_W      (3),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk          (clk),
        .clrn         (clrn),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .nextdata_n   (nextdata_n),
        .data         (data),
        .ready        (ready),
        .fifo_overflow(fifo_overflow),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // Every high cycle of frame_err is counted; one bad frame must give exactly one.
    always @(posedge clk) begin
        #1;
        if (frame_err === 1'b1) err_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_ready"}, {31'd0, ready}, {31'd0, q.size() != 0});
        check_eq({tag, "_ovf"}, {31'd0, fifo_overflow}, {31'd0, ovf_m});
        check_eq({tag, "_ferr_cnt"}, err_seen, err_exp);
        if (q.size() != 0) check_eq({tag, "_data"}, {24'd0, data}, {24'd0, q[0]});
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit flip_par,
                                               input bit bad_start, input bit bad_stop);
        logic par;
        par = ~(^b) ^ flip_par;   // odd parity over data + parity bit
        return {~bad_stop, par, b, bad_start};
    endfunction

    // Drives nbits bits of a frame (bit 0 first). All stimulus changes at negedge clk.
    // With pop_stop, nextdata_n is held low for the clk edge that completes the frame.
    task automatic ps2_bits(input logic [10:0] bits, input int nbits, input bit pop_stop);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (3) @(negedge clk);
            ps2_clk = 1'b0;                  // falls just before edge k
            if (pop_stop && i == 10) begin
                @(negedge clk);              // after edge k
                @(negedge clk);              // after edge k+1
                if (q.size() != 0) check_eq("pop_at_stop_head", {24'd0, data}, {24'd0, q[0]});
                nextdata_n = 1'b0;
                @(negedge clk);              // after edge k+2: frame done and pop together
                nextdata_n = 1'b1;
                repeat (3) @(negedge clk);
            end else begin
                repeat (6) @(negedge clk);
            end
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit flip_par, input bit bad_start,
                        input bit bad_stop);
        ps2_bits(make_frame(b, flip_par, bad_start, bad_stop), 11, 1'b0);
        if (flip_par || bad_start || bad_stop) begin
            err_exp++;
        end else if (q.size() < DEPTH) begin
            q.push_back(b);
        end else begin
            ovf_m = 1'b1;
        end
        check_state("send");
    endtask

    task automatic pop_byte();
        @(negedge clk) nextdata_n = 1'b0;
        @(negedge clk) nextdata_n = 1'b1;
        if (q.size() != 0) begin
            void'(q.pop_front());
            ovf_m = 1'b0;
        end
        check_state("pop");
    endtask

    task automatic do_reset();
        @(negedge clk) clrn = 1'b1;
        @(negedge clk) clrn = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        check_eq("rst_ready", {31'd0, ready}, 32'd0);
        check_eq("rst_data", {24'd0, data}, 32'd0);
        check_eq("rst_ovf", {31'd0, fifo_overflow}, 32'd0);
        check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
    endtask

    initial begin
        clrn       = 1'b1;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        repeat (3) @(negedge clk);
        do_reset();

        // 1) single good frame
        send(8'h1C, 0, 0, 0);

        // 2) three frames, popped in order, then a pop on empty
        send(8'hF0, 0, 0, 0);
        send(8'h1C, 0, 0, 0);
        repeat (4) pop_byte();
        send(8'h3A, 0, 0, 0);
        pop_byte();

        // 3) parity error on an empty FIFO
        send(8'h5A, 1, 0, 0);
        send(8'h5A, 0, 1, 0);
        send(8'h5A, 0, 0, 1);

        // 4) fill, overflow, drain
        for (int i = 0; i < 8; i++) send(8'(i), 0, 0, 0);
        send(8'h08, 0, 0, 0);
        check_eq("ovf_set", {31'd0, fifo_overflow}, 32'd1);
        pop_byte();
        check_eq("ovf_clr", {31'd0, fifo_overflow}, 32'd0);
        repeat (7) pop_byte();

        // 5) full FIFO with a pop on the completing edge
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 0, 0, 0);
        ps2_bits(make_frame(8'h09, 0, 0, 0), 11, 1'b1);
        void'(q.pop_front());
        q.push_back(8'h09);
        ovf_m = 1'b0;
        check_state("full_pop_push");
        repeat (8) pop_byte();

        // 6a) reset in the middle of a frame
        ps2_bits(make_frame(8'h77, 0, 0, 0), 5, 1'b0);
        do_reset();
        send(8'h29, 0, 0, 0);
        pop_byte();

        // 6b) stall after 4 bits until the partial frame is discarded
        ps2_bits(make_frame(8'h66, 0, 0, 0), 4, 1'b0);
        repeat (TIMEOUT + 20) @(negedge clk);
        send(8'h29, 0, 0, 0);
        pop_byte();

        // randomized mix of good frames, bad frames and pops
        for (int n = 0; n < 40; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                send(8'($urandom), 0, 0, 0);
            end else if (r == 6) begin
                int unsigned k;
                k = $urandom_range(0, 2);
                send(8'($urandom), k == 0, k == 1, k == 2);
            end else begin
                pop_byte();
            end
        end
        while (q.size() != 0) pop_byte();

        repeat (4) @(negedge clk);
        check_eq("frame_err_pulses", err_seen, err_exp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
